// File: rtl/kbd_matrix_map.sv
// kbd_matrix_map: maps PS/2-style scancodes onto a key matrix and modifier outputs, stretching short presses to a minimum hold
module kbd_matrix_map #(
  parameter int ROWS = 8,
  parameter int COLS = 8,
  parameter int NMOD = 3,
  parameter int HOLD_CYCLES = 50000,
  parameter int TS_W = 17,
  parameter int RQ_DEPTH = 4,
  localparam int RW = $clog2(ROWS),
  localparam int CW = $clog2(COLS),
  localparam int MW = 2 + ((RW + CW) > $clog2(NMOD) ? RW + CW : $clog2(NMOD))
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            code_ready,
  input  logic [9:0]      scancode,
  input  logic            map_we,
  input  logic [8:0]      map_addr,
  input  logic [MW-1:0]   map_wdata,
  input  logic            clear,
  input  logic [ROWS-1:0] row_sel,
  output logic [COLS-1:0] col_data,
  output logic [NMOD-1:0] mods,
  output logic            rq_overflow
);
  localparam int NK = ROWS * COLS;
  localparam int KW = $clog2(NK);
  localparam int QW = $clog2(RQ_DEPTH);
  localparam int AW = QW > 0 ? QW : 1;
  logic [MW-1:0] tbl [512];
  logic [MW-1:0] ent;
  logic v1, rel1;
  logic [TS_W-1:0] ts;
  logic [NK-1:0] mat;
  logic [TS_W-1:0] pts [NK];
  logic [KW-1:0] qk [RQ_DEPTH];
  logic [TS_W-1:0] qts [RQ_DEPTH];
  logic [RQ_DEPTH-1:0] qv;
  logic [AW-1:0] head, tail;
  logic [QW:0] cnt;
  logic [RW-1:0] row;
  logic [CW-1:0] col;
  logic [MW-3:0] idx;
  logic [KW-1:0] key;
  logic [TS_W-1:0] age, head_age;
  logic is_key, is_mod, press, rls, short_hold, full, push, pop;
  function automatic logic [AW-1:0] nxt(input logic [AW-1:0] p);
    return RQ_DEPTH == 1 ? '0 : p + 1'b1;
  endfunction
  assign row = ent[RW+CW-1:CW];
  assign col = ent[CW-1:0];
  assign idx = ent[MW-3:0];
  assign key = KW'(32'(row) * COLS + 32'(col));
  assign is_key = v1 && !clear && ent[MW-1] && !ent[MW-2] && 32'(row) < ROWS && 32'(col) < COLS;
  assign is_mod = v1 && !clear && ent[MW-1] && ent[MW-2] && 32'(idx) < NMOD;
  assign press = is_key && !rel1;
  assign rls = is_key && rel1;
  assign age = ts - pts[key];
  assign short_hold = age < TS_W'(HOLD_CYCLES);
  assign full = cnt == (QW+1)'(RQ_DEPTH);
  assign push = rls && short_hold && !full;
  assign head_age = ts - qts[head];
  // invalidated heads drain immediately; live heads wait until their key has been held long enough
  assign pop = !clear && cnt != '0 && (!qv[head] || head_age >= TS_W'(HOLD_CYCLES));
  always_comb begin
    col_data = '0;
    for (int r = 0; r < ROWS; r++) col_data = row_sel[r] ? col_data | mat[r*COLS +: COLS] : col_data;
  end
  always_ff @(posedge clk) begin
    if (map_we) tbl[map_addr] <= map_wdata;
    if (code_ready) begin
      ent <= tbl[{scancode[9], scancode[7:0]}];
      rel1 <= scancode[8];
    end
    if (press) pts[key] <= ts;
    if (push) begin
      qk[tail] <= key;
      qts[tail] <= pts[key];
    end
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ts <= '0;
      v1 <= 1'b0;
      mat <= '0;
      mods <= '0;
      rq_overflow <= 1'b0;
      qv <= '0;
      head <= '0;
      tail <= '0;
      cnt <= '0;
    end else begin
      ts <= ts + 1'b1;
      v1 <= code_ready && !clear;
      if (clear) begin
        mat <= '0;
        mods <= '0;
        rq_overflow <= 1'b0;
        head <= '0;
        tail <= '0;
        cnt <= '0;
      end else begin
        if (pop) begin
          head <= nxt(head);
          if (qv[head]) mat[qk[head]] <= 1'b0;
        end
        if (push) begin
          qv[tail] <= 1'b1;
          tail <= nxt(tail);
        end
        for (int i = 0; i < RQ_DEPTH; i++) if (press && qk[i] == key) qv[i] <= 1'b0;
        // a press lands after any pop clear, so it wins on the same key
        if (press) mat[key] <= 1'b1;
        else if (rls && (!short_hold || full)) mat[key] <= 1'b0;
        if (rls && short_hold && full) rq_overflow <= 1'b1;
        for (int i = 0; i < NMOD; i++) if (is_mod && 32'(idx) == i) mods[i] <= !rel1;
        cnt <= cnt + (QW+1)'(push) - (QW+1)'(pop);
      end
    end
  end
endmodule

// File: tb/tb_kbd_matrix_map.sv
// tb_kbd_matrix_map: directed scenarios plus random traffic, checked every cycle against a queue-based reference model
module tb_kbd_matrix_map;
  localparam int HOLD = 100;
  logic clk, reset, code_ready, map_we, clear, rq_overflow;
  logic [9:0] scancode;
  logic [8:0] map_addr;
  logic [7:0] map_wdata;
  logic [5:0] row_sel;
  logic [4:0] col_data;
  logic [2:0] mods;
  bit fix;
  int passed, total;

  kbd_matrix_map #(.ROWS(6), .COLS(5), .NMOD(3), .HOLD_CYCLES(HOLD), .TS_W(8), .RQ_DEPTH(4)) dut (
    .clk(clk), .reset(reset), .code_ready(code_ready), .scancode(scancode),
    .map_we(map_we), .map_addr(map_addr), .map_wdata(map_wdata), .clear(clear),
    .row_sel(row_sel), .col_data(col_data), .mods(mods), .rq_overflow(rq_overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string n, input int a, input int e);
    total++;
    if (a == e) passed++;
    else $display("FAIL %s: got %0h expected %0h at %0t", n, a, e, $time);
  endtask

  // reference model: keys as a flat array, release queue as an SV queue of pending releases
  typedef struct { int key; int pts; bit ok; } qe_t;
  typedef struct { bit [29:0] mat; bit [2:0] mods; bit ovf; } exp_t;
  qe_t rq[$];
  exp_t sb[$];
  logic [7:0] m_tbl [512];
  bit [29:0] m_mat;
  bit [2:0] m_mods;
  bit m_ovf, p_v, p_rel;
  logic [7:0] p_ent;
  int m_ts;
  int m_pts [30];

  task automatic apply(input logic [7:0] e, input bit rel, input bit full);
    int r, c, k, age;
    if (e[7] !== 1'b1) return;
    if (e[6]) begin
      if (e[5:0] < 3) m_mods[e[5:0]] = !rel;
      return;
    end
    r = int'(e[5:3]);
    c = int'(e[2:0]);
    if (r >= 6 || c >= 5) return;
    k = r * 5 + c;
    if (!rel) begin
      m_mat[k] = 1'b1;
      m_pts[k] = m_ts;
      foreach (rq[i]) if (rq[i].key == k) rq[i].ok = 1'b0;
    end else begin
      age = (m_ts - m_pts[k]) & 255;
      if (age >= HOLD) m_mat[k] = 1'b0;
      else if (full) begin
        m_mat[k] = 1'b0;
        m_ovf = 1'b1;
      end else rq.push_back('{k, m_pts[k], 1'b1});
    end
  endtask

  always @(posedge clk) begin
    bit full;
    if (reset) begin
      m_mat = '0; m_mods = '0; m_ovf = 1'b0; rq.delete(); p_v = 1'b0; m_ts = 0;
    end else begin
      if (clear) begin
        m_mat = '0; m_mods = '0; m_ovf = 1'b0; rq.delete(); p_v = 1'b0;
      end else begin
        full = rq.size() == 4;
        if (rq.size() > 0) begin
          if (!rq[0].ok) void'(rq.pop_front());
          else if (((m_ts - rq[0].pts) & 255) >= HOLD) begin
            m_mat[rq[0].key] = 1'b0;
            void'(rq.pop_front());
          end
        end
        if (p_v) apply(p_ent, p_rel, full);
        p_v = code_ready;
        if (code_ready) begin
          p_ent = m_tbl[{scancode[9], scancode[7:0]}];
          p_rel = scancode[8];
        end
      end
      if (map_we) m_tbl[map_addr] = map_wdata;
      m_ts = (m_ts + 1) & 255;
    end
    sb.push_back('{m_mat, m_mods, m_ovf});
  end

  always @(negedge clk) begin
    if (sb.size() > 0) begin
      exp_t x;
      logic [4:0] ec;
      x = sb.pop_front();
      if (reset) x = '{'0, '0, 1'b0};
      ec = '0;
      for (int r = 0; r < 6; r++) if (row_sel[r]) ec = ec | x.mat[r*5 +: 5];
      chk("mon_col_data", int'(col_data), int'(ec));
      chk("mon_mods", int'(mods), int'(x.mods));
      chk("mon_rq_overflow", int'(rq_overflow), int'(x.ovf));
    end
  end

  initial forever begin
    @(posedge clk);
    #2;
    if (!fix) row_sel = 6'($urandom);
  end

  function automatic logic [7:0] kent(input int r, input int c);
    return {2'b10, 3'(r), 3'(c)};
  endfunction
  function automatic logic [7:0] rnd_ent();
    int p = $urandom_range(0, 9);
    if (p == 0) return {1'b0, 7'($urandom)};
    if (p == 1) return {2'b11, 6'($urandom_range(0, 4))};
    return {2'b10, 3'($urandom_range(0, 6)), 3'($urandom_range(0, 5))};
  endfunction
  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic send(input logic [9:0] sc);
    scancode = sc;
    code_ready = 1'b1;
    @(posedge clk);
    #1;
    code_ready = 1'b0;
  endtask
  task automatic wr(input logic [8:0] a, input logic [7:0] d);
    map_addr = a;
    map_wdata = d;
    map_we = 1'b1;
    @(posedge clk);
    #1;
    map_we = 1'b0;
  endtask
  task automatic do_clear();
    clear = 1'b1;
    @(posedge clk);
    #1;
    clear = 1'b0;
  endtask

  initial begin
    fix = 1'b1; reset = 1'b1; code_ready = 1'b0; map_we = 1'b0; clear = 1'b0;
    scancode = '0; map_addr = '0; map_wdata = '0; row_sel = 6'h3F;
    idle(3);
    chk("reset_col_data", int'(col_data), 0);
    chk("reset_mods", int'(mods), 0);
    chk("reset_ovf", int'(rq_overflow), 0);
    reset = 1'b0;
    idle(2);
    // short press of row 1 col 4 held until 100 cycles after the press
    wr(9'h01C, kent(1, 4));
    row_sel = 6'h02;
    send(10'h01C);
    chk("press_latency_early", int'(col_data), 0);
    idle(1);
    chk("press_latency", int'(col_data), 'h10);
    idle(8);
    send(10'h11C);
    idle(90);
    chk("hold_before_expiry", int'(col_data), 'h10);
    idle(1);
    chk("hold_after_expiry", int'(col_data), 0);
    // extended prefix selects a separate table half
    wr(9'h175, kent(5, 1));
    wr(9'h075, kent(2, 0));
    send(10'h275);
    idle(1);
    row_sel = 6'h20;
    #1 chk("ext_row5", int'(col_data), 'h02);
    row_sel = 6'h04;
    #1 chk("ext_row2_untouched", int'(col_data), 0);
    send(10'h075);
    idle(1);
    row_sel = 6'h04;
    #1 chk("plain_row2", int'(col_data), 'h01);
    // modifiers and ignored entries
    wr(9'h012, {2'b11, 6'd0});
    wr(9'h059, {2'b11, 6'd0});
    wr(9'h013, {2'b11, 6'd5});
    wr(9'h014, {2'b10, 3'd0, 3'd7});
    wr(9'h015, {2'b00, 3'd3, 3'd3});
    send(10'h012);
    idle(1);
    chk("mod_press", int'(mods), 1);
    send(10'h013);
    idle(1);
    chk("mod_bad_index", int'(mods), 1);
    send(10'h112);
    idle(1);
    chk("mod_release", int'(mods), 0);
    send(10'h014);
    send(10'h015);
    idle(1);
    row_sel = 6'h0A;
    #1 chk("ignored_entries", int'(col_data), 0);
    // re-press before hold expiry keeps the key down
    wr(9'h030, kent(3, 3));
    row_sel = 6'h08;
    send(10'h030);
    idle(5);
    send(10'h130);
    idle(10);
    send(10'h030);
    idle(101);
    chk("repress_survives_pop", int'(col_data), 'h08);
    send(10'h130);
    idle(1);
    chk("long_release", int'(col_data), 0);
    // five short releases overflow a four-entry queue
    for (int i = 0; i < 5; i++) wr(9'(32'h20 + i), kent(0, i));
    for (int i = 0; i < 5; i++) send(10'(32'h20 + i));
    for (int i = 0; i < 5; i++) send(10'(32'h120 + i));
    idle(1);
    row_sel = 6'h01;
    #1 chk("overflow_bits", int'(col_data), 'h0F);
    chk("overflow_flag", int'(rq_overflow), 1);
    idle(120);
    chk("overflow_drained", int'(col_data), 0);
    chk("overflow_sticky", int'(rq_overflow), 1);
    do_clear();
    chk("overflow_cleared", int'(rq_overflow), 0);
    // clear with keys held, releases queued and codes in flight
    for (int i = 0; i < 7; i++) wr(9'(32'h40 + i), kent(i < 3 ? 4 : (i < 5 ? 5 : 2), i < 3 ? i : (i < 5 ? i : i - 3)));
    row_sel = 6'h3F;
    send(10'h040); send(10'h041); send(10'h042); send(10'h012);
    send(10'h043); send(10'h044); send(10'h143); send(10'h144);
    idle(1);
    chk("pre_clear_cols", int'(col_data), 'h1F);
    chk("pre_clear_mods", int'(mods), 1);
    scancode = 10'h045;
    code_ready = 1'b1;
    @(posedge clk);
    #1;
    scancode = 10'h046;
    clear = 1'b1;
    @(posedge clk);
    #1;
    code_ready = 1'b0;
    clear = 1'b0;
    chk("clear_cols", int'(col_data), 0);
    chk("clear_mods", int'(mods), 0);
    chk("clear_ovf", int'(rq_overflow), 0);
    idle(2);
    chk("inflight_lost", int'(col_data), 0);
    idle(300);
    chk("wrap_no_pop", int'(col_data), 0);
    for (int i = 0; i < 4; i++) send(10'(32'h20 + i));
    for (int i = 0; i < 4; i++) send(10'(32'h120 + i));
    idle(1);
    chk("queue_empty_after_clear", int'(rq_overflow), 0);
    chk("queue_refill_bits", int'(col_data), 'h0F);
    idle(110);
    // random phase: every key gets a known press time first
    for (int k = 0; k < 30; k++) wr(9'(32'h100 + k), kent(k / 5, k % 5));
    for (int k = 0; k < 30; k++) send(10'(32'h200 + k));
    idle(1);
    chk("all_keys", int'(col_data), 'h1F);
    do_clear();
    for (int a = 0; a < 64; a++) wr(9'(a), rnd_ent());
    fix = 1'b0;
    for (int n = 0; n < 4000; n++) begin
      int p;
      p = $urandom_range(0, 999);
      code_ready = p < 500;
      if ($urandom_range(0, 3) == 0) scancode = {1'b1, 1'($urandom), 8'($urandom_range(0, 29))};
      else scancode = {1'b0, 1'($urandom), 8'($urandom_range(0, 63))};
      map_we = p >= 500 && p < 560;
      map_addr = 9'($urandom_range(0, 63));
      map_wdata = rnd_ent();
      clear = p >= 990 && p < 996;
      reset = p >= 996;
      if (reset) map_we = 1'b0;
      @(posedge clk);
      #1;
    end
    code_ready = 1'b0; map_we = 1'b0; clear = 1'b0; reset = 1'b0;
    idle(3);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
